// File: rtl/bus_arb_pkg.sv
// ============================================================================
// Module : bus_arb_pkg
// Brief  : State encoding and owner constants for the two-master bus arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic OWNER0 = 1'b0;
    localparam logic OWNER1 = 1'b1;

    function automatic state_t own_state(input logic owner);
        return (owner == OWNER1) ? OWN1 : OWN0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_2to1.sv
// ============================================================================
// Module : mux_2to1
// Brief  : Single-bit 2:1 multiplexer (sel=0 -> a, sel=1 -> b).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_2to1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

`default_nettype wire

// File: rtl/mux_bus_arbiter.sv
// ============================================================================
// Module : mux_bus_arbiter
// Brief  : Round-robin two-master arbiter with burst limit driving the shared
//          bus mux select and a registered bus word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_valid
);

    localparam int                 c_CNT_W     = $clog2(MAX_HOLD) + 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(MAX_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = '1;

    state_t               r_state;
    logic                 r_last_owner;
    logic [c_CNT_W-1:0]   r_hold_cnt;

    state_t               w_next_state;
    state_t               w_other_state;
    logic [c_CNT_W-1:0]   w_next_hold;
    logic                 w_own_is1;
    logic                 w_req_own;
    logic                 w_req_oth;
    logic [DATA_W-1:0]    w_mux_y;

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mux
        mux_2to1 u_mux (
            .a   (data0[gi]),
            .b   (data1[gi]),
            .sel (sel),
            .y   (w_mux_y[gi])
        );
    end

    always_comb begin
        w_own_is1     = (r_state == OWN1);
        w_req_own     = w_own_is1 ? req1 : req0;
        w_req_oth     = w_own_is1 ? req0 : req1;
        w_other_state = w_own_is1 ? OWN0 : OWN1;
        w_next_state  = r_state;
        w_next_hold   = '0;
        case (r_state)
            IDLE: begin
                if (req0 && req1)
                    w_next_state = own_state(!r_last_owner);
                else if (req0)
                    w_next_state = OWN0;
                else if (req1)
                    w_next_state = OWN1;
            end
            OWN0, OWN1: begin
                if (!w_req_own) begin
                    w_next_state = w_req_oth ? w_other_state : IDLE;
                end else if (w_req_oth) begin
                    // Burst limit reached: hand straight over, no idle bubble
                    if (r_hold_cnt == c_HOLD_LAST)
                        w_next_state = w_other_state;
                    else if (r_hold_cnt == c_CNT_MAX)
                        w_next_hold = r_hold_cnt;
                    else
                        w_next_hold = r_hold_cnt + c_CNT_W'(1);
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_owner <= OWNER1;
            r_hold_cnt   <= '0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            sel          <= 1'b0;
            bus_out      <= '0;
            bus_valid    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_hold_cnt <= w_next_hold;
            gnt0       <= (w_next_state == OWN0);
            gnt1       <= (w_next_state == OWN1);
            sel        <= (w_next_state == OWN1);
            if (w_next_state != IDLE)
                r_last_owner <= (w_next_state == OWN1) ? OWNER1 : OWNER0;
            bus_valid  <= (gnt0 && req0) || (gnt1 && req1);
            if (r_state != IDLE)
                bus_out <= w_mux_y;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));

endmodule

`default_nettype wire

// File: tb/tb_mux_bus_arbiter.sv
// ============================================================================
// Module : tb_mux_bus_arbiter
// Brief  : Randomized and directed bench for mux_bus_arbiter (MAX_HOLD=4 and 1).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;

    logic       gnt0_a, gnt1_a, sel_a, bus_valid_a;
    logic [7:0] bus_out_a;
    logic       gnt0_b, gnt1_b, sel_b, bus_valid_b;
    logic [7:0] bus_out_b;

    logic [11:0] obs_a;
    logic [11:0] obs_b;
    assign obs_a = {gnt0_a, gnt1_a, sel_a, bus_valid_a, bus_out_a};
    assign obs_b = {gnt0_b, gnt1_b, sel_b, bus_valid_b, bus_out_b};

    int errors = 0;
    int checks = 0;

    // Reference model: owner -1 means nobody holds the bus
    int         m_owner [2];
    int         m_last  [2];
    int         m_cnt   [2];
    logic [7:0] m_bus   [2];
    logic       m_valid [2];
    int         maxh    [2] = '{4, 1};

    mux_bus_arbiter #(.DATA_W(8), .MAX_HOLD(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .sel(sel_a),
        .bus_out(bus_out_a), .bus_valid(bus_valid_a)
    );

    mux_bus_arbiter #(.DATA_W(8), .MAX_HOLD(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .sel(sel_b),
        .bus_out(bus_out_b), .bus_valid(bus_valid_b)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_vec(input int k);
        return {m_owner[k] == 0, m_owner[k] == 1, m_owner[k] == 1, m_valid[k], m_bus[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_last[k]  = 1;
            m_cnt[k]   = 0;
            m_bus[k]   = 8'h00;
            m_valid[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        int r [2];
        r[0] = int'(req0);
        r[1] = int'(req1);
        for (int k = 0; k < 2; k++) begin
            int o;
            int nxt;
            o = m_owner[k];
            if (o >= 0) begin
                m_bus[k]   = (o == 1) ? data1 : data0;
                m_valid[k] = (r[o] == 1);
            end else begin
                m_valid[k] = 1'b0;
            end
            if (o < 0) begin
                if (r[0] == 1 && r[1] == 1) nxt = 1 - m_last[k];
                else if (r[0] == 1)         nxt = 0;
                else if (r[1] == 1)         nxt = 1;
                else                        nxt = -1;
                m_cnt[k] = 0;
            end else if (r[o] == 0) begin
                nxt = (r[1-o] == 1) ? 1 - o : -1;
                m_cnt[k] = 0;
            end else if (r[1-o] == 0) begin
                nxt = o;
                m_cnt[k] = 0;
            end else if (m_cnt[k] + 1 >= maxh[k]) begin
                nxt = 1 - o;
                m_cnt[k] = 0;
            end else begin
                nxt = o;
                m_cnt[k] = m_cnt[k] + 1;
            end
            if (nxt >= 0) m_last[k] = nxt;
            m_owner[k] = nxt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        req0 = 1'b1; req1 = 1'b1;
        data0 = 8'hFF; data1 = 8'hEE;
        repeat (3) tick();
        checks++;
        if (obs_a !== 12'h000) begin
            errors++;
            $display("FAIL reset_a: got %h want %h", obs_a, 12'h000);
        end
        checks++;
        if (obs_b !== 12'h000) begin
            errors++;
            $display("FAIL reset_b: got %h want %h", obs_b, 12'h000);
        end
    endtask

    task automatic test_single_req();
        apply_reset();
        req0 = 1'b1; data0 = 8'hA5; data1 = 8'h5A;
        tick();
        checks++;
        if ({gnt0_a, gnt1_a, bus_valid_a} !== 3'b100) begin
            errors++;
            $display("FAIL single_gnt: got %b want %b", {gnt0_a, gnt1_a, bus_valid_a}, 3'b100);
        end
        tick();
        checks++;
        if ({bus_valid_a, bus_out_a} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL single_bus: got %h want %h", {bus_valid_a, bus_out_a}, {1'b1, 8'hA5});
        end
        req0 = 1'b0;
        tick();
        checks++;
        if (gnt0_a !== 1'b0) begin
            errors++;
            $display("FAIL single_drop: got %b want 0", gnt0_a);
        end
        tick();
        checks++;
        if (obs_a !== exp_vec(0)) begin
            errors++;
            $display("FAIL single_idle_model: got %h want %h", obs_a, exp_vec(0));
        end
    endtask

    task automatic test_tie_burst();
        logic g0;
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            tick();
            g0 = ((i / 4) % 2 == 0);
            checks++;
            if ({gnt0_a, gnt1_a, sel_a} !== {g0, !g0, !g0}) begin
                errors++;
                $display("FAIL tie_burst cyc %0d: got %b want %b", i, {gnt0_a, gnt1_a, sel_a}, {g0, !g0, !g0});
            end
            checks++;
            if (obs_a !== exp_vec(0)) begin
                errors++;
                $display("FAIL tie_model cyc %0d: got %h want %h", i, obs_a, exp_vec(0));
            end
        end
    endtask

    task automatic test_handover();
        int n;
        n = 0;
        while (gnt1_a !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (gnt1_a !== 1'b1) begin
            errors++;
            $display("FAIL handover_wait: got gnt1=%b want 1 within 10 cycles", gnt1_a);
        end
        req1 = 1'b0; req0 = 1'b1;
        data0 = 8'h3C; data1 = 8'hC3;
        tick();
        checks++;
        if ({gnt0_a, gnt1_a, bus_out_a} !== {2'b10, 8'hC3}) begin
            errors++;
            $display("FAIL handover_gnt: got %h want %h", {gnt0_a, gnt1_a, bus_out_a}, {2'b10, 8'hC3});
        end
        tick();
        checks++;
        if ({bus_valid_a, bus_out_a} !== {1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL handover_bus: got %h want %h", {bus_valid_a, bus_out_a}, {1'b1, 8'h3C});
        end
    endtask

    task automatic test_midburst_reset();
        int n;
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        data0 = 8'h11; data1 = 8'h22;
        n = 0;
        while (gnt1_a !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        repeat (2) tick();
        checks++;
        if (gnt1_a !== 1'b1) begin
            errors++;
            $display("FAIL midburst_own1: got gnt1=%b want 1", gnt1_a);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({obs_a, obs_b} !== 24'h0) begin
            errors++;
            $display("FAIL midburst_async: got %h want %h", {obs_a, obs_b}, 24'h0);
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({gnt0_a, gnt1_a} !== 2'b10) begin
            errors++;
            $display("FAIL midburst_first_owner: got %b want %b", {gnt0_a, gnt1_a}, 2'b10);
        end
        checks++;
        if (obs_b !== exp_vec(1)) begin
            errors++;
            $display("FAIL midburst_model_b: got %h want %h", obs_b, exp_vec(1));
        end
    endtask

    task automatic test_max_hold1();
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            tick();
            checks++;
            if ({gnt0_b, gnt1_b} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL hold1_alt cyc %0d: got %b want %b", i, {gnt0_b, gnt1_b}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (i >= 1) begin
                checks++;
                if (bus_valid_b !== 1'b1) begin
                    errors++;
                    $display("FAIL hold1_valid cyc %0d: got %b want 1", i, bus_valid_b);
                end
            end
            checks++;
            if (obs_b !== exp_vec(1)) begin
                errors++;
                $display("FAIL hold1_model cyc %0d: got %h want %h", i, obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            req0  = ($urandom_range(0, 3) != 0);
            req1  = ($urandom_range(0, 3) != 0);
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            tick();
            checks++;
            if (obs_a !== exp_vec(0)) begin
                errors++;
                $display("FAIL rand_a cyc %0d: got %h want %h", i, obs_a, exp_vec(0));
            end
            checks++;
            if (obs_b !== exp_vec(1)) begin
                errors++;
                $display("FAIL rand_b cyc %0d: got %h want %h", i, obs_b, exp_vec(1));
            end
            checks++;
            if ((gnt0_a && gnt1_a) || (gnt0_b && gnt1_b)) begin
                errors++;
                $display("FAIL rand_onehot cyc %0d: got a=%b%b b=%b%b want not both", i, gnt0_a, gnt1_a, gnt0_b, gnt1_b);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_req();
        test_tie_burst();
        test_handover();
        test_midburst_reset();
        test_max_hold1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
